// File: rtl/ulv_shift_reg_pkg.sv
// ---------------------------------------------------------------------------
// ulv_shift_reg_pkg
//   Shared definitions for the universal shift register.
//   Any controller or bench that drives ctrl should import this package.
//
//   ctrl_e : the 2-bit operation select
//            HOLD = 00, SHL = 01, SHR = 10, LOAD = 11
// ---------------------------------------------------------------------------
package ulv_shift_reg_pkg;

    typedef enum logic [1:0] {
        CTRL_HOLD = 2'b00,
        CTRL_SHL  = 2'b01,
        CTRL_SHR  = 2'b10,
        CTRL_LOAD = 2'b11
    } ctrl_e;

endpackage : ulv_shift_reg_pkg

// File: rtl/ulv_shift_register.sv
// ---------------------------------------------------------------------------
// ulv_shift_register
//   N-bit universal shift register. On every rising edge of clk it performs
//   exactly one operation: hold, shift left, shift right, or parallel load.
//
//   Parameters
//     N      register width in bits (N >= 2)
//
//   Ports
//     clk    in   1   clock, all state changes on the rising edge
//     reset  in   1   synchronous active-high clear, overrides every ctrl value
//     ctrl   in   2   operation select (see ctrl_e in ulv_shift_reg_pkg)
//     d      in   N   parallel load data; d[0] is the SHL serial-in bit and
//                     d[N-1] is the SHR serial-in bit
//     q      out  N   register contents, driven straight from the flops
// ---------------------------------------------------------------------------
module ulv_shift_register
    import ulv_shift_reg_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   ctrl,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // A one-bit register has no meaningful shift slices; refuse to build it.
    generate
        if (N < 2) begin : g_bad_width
            $fatal(1, "ulv_shift_register: N must be >= 2");
        end
    endgenerate

    logic [N-1:0] q_reg;
    logic [N-1:0] q_next;

    // Next-state selection. Shifts are logical: the only bit entering the
    // register is the chosen serial-in bit, and the bit pushed out is lost.
    always_comb begin
        q_next = q_reg;
        unique case (ctrl_e'(ctrl))
            CTRL_HOLD: q_next = q_reg;
            CTRL_SHL:  q_next = {q_reg[N-2:0], d[0]};
            CTRL_SHR:  q_next = {d[N-1], q_reg[N-1:1]};
            CTRL_LOAD: q_next = d;
            default:   q_next = q_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule : ulv_shift_register

// File: tb/tb_ulv_shift_register.sv
// ---------------------------------------------------------------------------
// tb_ulv_shift_register
//   Self-checking bench for ulv_shift_register (N = 8, 20 ns clock).
//   Inputs change on the falling edge; q is sampled 1 ns after the rising
//   edge. Expected values come from the directed scenarios and from an
//   arithmetic reference model (multiply/divide by two plus serial-in bit).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ulv_shift_register;
    import ulv_shift_reg_pkg::*;

    localparam int N = 8;

    logic         clk;
    logic         reset;
    logic [1:0]   ctrl;
    logic [N-1:0] d;
    logic [N-1:0] q;

    int checks = 0;
    int errors = 0;
    int model  = 0;   // reference value of q, kept as a plain integer

    ulv_shift_register #(.N(N)) ulv_shift_reg (
        .clk   (clk),
        .reset (reset),
        .ctrl  (ctrl),
        .d     (d),
        .q     (q)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference behaviour in arithmetic terms.
    function automatic int ref_next(int cur, bit r, int c, int dv);
        if (r) return 0;
        case (c)
            0:       return cur;
            1:       return (cur * 2 + dv % 2) % 256;      // SHL, serial-in d[0]
            2:       return cur / 2 + (dv / 128) * 128;    // SHR, serial-in d[7]
            default: return dv;                            // LOAD
        endcase
    endfunction

    // One clock: drive on the falling edge, sample after the rising edge,
    // and compare q against the reference model.
    task automatic step(input bit r, input ctrl_e c, input logic [7:0] dv);
        logic [7:0] exp_q;
        @(negedge clk);
        reset = r;
        ctrl  = c;
        d     = dv;
        @(posedge clk);
        #1;
        model = ref_next(model, r, int'(c), int'(dv));
        exp_q = model[7:0];
        checks++;
        assert (q === exp_q)
        else begin
            errors++;
            $error("FAIL model r=%0b ctrl=%0d d=%02h: q=%02h expected %02h",
                   r, c, dv, q, exp_q);
        end
        $display("step r=%0b ctrl=%0d d=%02h q=%02h", r, c, dv, q);
    endtask

    // Compare q against a value written directly from the scenario.
    task automatic expect_q(input string tag, input logic [7:0] exp_q);
        checks++;
        assert (q === exp_q)
        else begin
            errors++;
            $error("FAIL %s: q=%02h expected %02h", tag, q, exp_q);
        end
    endtask

    initial begin
        reset = 1'b0;
        ctrl  = CTRL_HOLD;
        d     = '0;

        // 1. Reset wins over LOAD.
        step(1'b1, CTRL_LOAD, 8'h05);
        expect_q("reset", 8'h00);

        // 2. Load, then hold while d changes.
        step(1'b0, CTRL_LOAD, 8'h05);
        expect_q("load05", 8'h05);
        for (int i = 6; i <= 10; i++) begin
            step(1'b0, CTRL_HOLD, 8'(i));
            expect_q("hold", 8'h05);
        end

        // 3. Shift left with serial-in 0, MSB falls off.
        step(1'b0, CTRL_LOAD, 8'h0A);
        expect_q("load0A", 8'h0A);
        step(1'b0, CTRL_SHL, 8'h0A); expect_q("shl1", 8'h14);
        step(1'b0, CTRL_SHL, 8'h0A); expect_q("shl2", 8'h28);
        step(1'b0, CTRL_SHL, 8'h0A); expect_q("shl3", 8'h50);
        step(1'b0, CTRL_SHL, 8'h0A); expect_q("shl4", 8'hA0);
        step(1'b0, CTRL_SHL, 8'h0A); expect_q("shl5", 8'h40);

        // 4. Shift right with serial-in 1 at the MSB.
        step(1'b0, CTRL_LOAD, 8'h81);
        expect_q("load81", 8'h81);
        step(1'b0, CTRL_SHR, 8'h80); expect_q("shr1", 8'hC0);
        step(1'b0, CTRL_SHR, 8'h80); expect_q("shr2", 8'hE0);

        // 5. Serial fill from d[0].
        step(1'b1, CTRL_HOLD, 8'h00);
        expect_q("reset2", 8'h00);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, CTRL_SHL, 8'h01);
            expect_q("serial_in", 8'((1 << (i + 1)) - 1));
        end

        // 6. Reset in the middle of a right-shift run, then resume.
        step(1'b0, CTRL_SHR, 8'h80); expect_q("shr_ff", 8'hFF);
        step(1'b1, CTRL_SHR, 8'h80); expect_q("reset_mid", 8'h00);
        step(1'b0, CTRL_SHR, 8'h80); expect_q("resume1", 8'h80);
        step(1'b0, CTRL_SHR, 8'h80); expect_q("resume2", 8'hC0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) == 0),
                 ctrl_e'($urandom_range(0, 3)),
                 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ulv_shift_register
